// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Helpers for magnitude and conditional negation are used by the divide
// path, which is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic        OP_MUL      = 1'b0;
  localparam logic        OP_DIV      = 1'b1;
  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_LO     = 32'hFFFFFFFF;

  // Two's complement magnitude; 0x80000000 maps to itself (read as unsigned 2^31).
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // Negate v when neg is set.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit combinational adder/subtractor shared by the Booth step and the
// restoring-divide trial subtraction.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  // Single adder: subtract when sub is set, otherwise add.
  always_comb begin
    if (sub) begin
      y = a - b;
    end else begin
      y = a + b;
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and 32/32 divide
// (magnitude restoring) unit, one bit per clock, 64-bit HI/LO result.
// Optional feature macro: MULDIV_DIV_EN. When undefined, no divide
// hardware is built and a divide request completes quickly with err=1.
module mul_div_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             err
);

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   ZERO_W1  = {(WIDTH + 1){1'b0}};
  localparam logic [4:0]       LAST_CNT = 5'(MULDIV_ITER - 1);

  state_t           state_r;
  logic [4:0]       cnt_r;
  logic             op_r;
  logic [WIDTH-1:0] mcand_r;   // B for multiply, |B| for divide
  logic [WIDTH:0]   p_hi_r;    // Booth upper accumulator / divide remainder
  logic [WIDTH-1:0] p_lo_r;    // Booth lower accumulator / divide quotient
  logic             q_m1_r;    // Booth q(-1)
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             err_r;
`ifdef MULDIV_DIV_EN
  logic             sign_q_r;
  logic             sign_r_r;
  logic             div0_r;
`endif

  logic [WIDTH:0]   booth_b_s;
  logic             booth_sub_s;
  logic [WIDTH:0]   add_a_s;
  logic [WIDTH:0]   add_b_s;
  logic             add_sub_s;
  logic [WIDTH:0]   sum_s;
  logic             accept_s;

  assign busy = busy_r;
  assign done = done_r;
  assign HI   = hi_r;
  assign LO   = lo_r;
  assign err  = err_r;

  // Booth recoding of {q0, q-1}: add B, subtract B, or pass through.
  always_comb begin
    booth_b_s   = ZERO_W1;
    booth_sub_s = 1'b0;
    case ({p_lo_r[0], q_m1_r})
      2'b01: begin
        booth_b_s   = {mcand_r[WIDTH-1], mcand_r};
        booth_sub_s = 1'b0;
      end
      2'b10: begin
        booth_b_s   = {mcand_r[WIDTH-1], mcand_r};
        booth_sub_s = 1'b1;
      end
      default: begin
        booth_b_s   = ZERO_W1;
        booth_sub_s = 1'b0;
      end
    endcase
  end

`ifdef MULDIV_DIV_EN
  // Adder operand select: trial subtraction of |B| from the shifted remainder, or the Booth step.
  always_comb begin
    add_a_s   = p_hi_r;
    add_b_s   = booth_b_s;
    add_sub_s = booth_sub_s;
    if (op_r == OP_DIV) begin
      add_a_s   = {p_hi_r[WIDTH-1:0], p_lo_r[WIDTH-1]};
      add_b_s   = {1'b0, mcand_r};
      add_sub_s = 1'b1;
    end else begin
      add_a_s   = p_hi_r;
      add_b_s   = booth_b_s;
      add_sub_s = booth_sub_s;
    end
  end
`else
  // Adder operand select: only the Booth step exists without the divide datapath.
  always_comb begin
    add_a_s   = p_hi_r;
    add_b_s   = booth_b_s;
    add_sub_s = booth_sub_s;
  end
`endif

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a   (add_a_s),
    .b   (add_b_s),
    .sub (add_sub_s),
    .y   (sum_s)
  );

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

  // Control FSM, iteration counter, operand/accumulator registers and result registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r  <= IDLE;
      cnt_r    <= 5'd0;
      op_r     <= OP_MUL;
      mcand_r  <= ZERO_W;
      p_hi_r   <= ZERO_W1;
      p_lo_r   <= ZERO_W;
      q_m1_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      err_r    <= 1'b0;
`ifdef MULDIV_DIV_EN
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      div0_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      op_r    <= op;
      cnt_r   <= 5'd0;
      p_hi_r  <= ZERO_W1;
      q_m1_r  <= 1'b0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
      if (op == OP_DIV) begin
        sign_q_r <= A[WIDTH-1] ^ B[WIDTH-1];
        sign_r_r <= A[WIDTH-1];
        mcand_r  <= abs32(B);
        if (B == ZERO_W) begin
          // Keep the raw dividend so it can be returned in HI.
          div0_r  <= 1'b1;
          p_lo_r  <= A;
          state_r <= FIX;
        end else begin
          div0_r  <= 1'b0;
          p_lo_r  <= abs32(A);
          state_r <= CALC;
        end
      end else begin
        sign_q_r <= 1'b0;
        sign_r_r <= 1'b0;
        div0_r   <= 1'b0;
        mcand_r  <= B;
        p_lo_r   <= A;
        state_r  <= CALC;
      end
`else
      mcand_r <= B;
      p_lo_r  <= A;
      state_r <= (op == OP_DIV) ? FIX : CALC;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          if (op_r == OP_DIV) begin
            if (!sum_s[WIDTH]) begin
              p_hi_r <= sum_s;
              p_lo_r <= {p_lo_r[WIDTH-2:0], 1'b1};
            end else begin
              p_hi_r <= {1'b0, p_hi_r[WIDTH-2:0], p_lo_r[WIDTH-1]};
              p_lo_r <= {p_lo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            p_hi_r <= {sum_s[WIDTH], sum_s[WIDTH:1]};
            p_lo_r <= {sum_s[0], p_lo_r[WIDTH-1:1]};
            q_m1_r <= p_lo_r[0];
          end
`else
          p_hi_r <= {sum_s[WIDTH], sum_s[WIDTH:1]};
          p_lo_r <= {sum_s[0], p_lo_r[WIDTH-1:1]};
          q_m1_r <= p_lo_r[0];
`endif
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
`ifdef MULDIV_DIV_EN
          if (op_r == OP_DIV) begin
            if (div0_r) begin
              hi_r  <= p_lo_r;
              lo_r  <= DIV0_LO;
              err_r <= 1'b1;
            end else begin
              hi_r  <= neg_if(p_hi_r[WIDTH-1:0], sign_r_r);
              lo_r  <= neg_if(p_lo_r, sign_q_r);
              err_r <= 1'b0;
            end
          end else begin
            hi_r  <= p_hi_r[WIDTH-1:0];
            lo_r  <= p_lo_r;
            err_r <= 1'b0;
          end
`else
          if (op_r == OP_DIV) begin
            hi_r  <= ZERO_W;
            lo_r  <= ZERO_W;
            err_r <= 1'b1;
          end else begin
            hi_r  <= p_hi_r[WIDTH-1:0];
            lo_r  <= p_lo_r;
            err_r <= 1'b0;
          end
`endif
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: a table of directed vectors plus
// hand-written sequences for back-to-back issue, mid-operation clear and
// input changes while busy. Expectations follow MULDIV_DIV_EN.
module tb_mul_div_seq;

  logic        clk;
  logic        clr;
  logic [31:0] A;
  logic [31:0] B;
  logic        op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        err;

  int n_chk;
  int n_fail;

  mul_div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .A     (A),
    .B     (B),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives the request in the current cycle t and returns at the negedge of
  // the cycle where done is seen (or after a 60-cycle bound).
  task automatic run_op(input logic o, input logic [31:0] ta, input logic [31:0] tbv,
                        output int lat, output logic busy1, output logic busyd,
                        output logic [31:0] hi, output logic [31:0] lo, output logic e);
    op    = o;
    A     = ta;
    B     = tbv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    lat   = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    busyd = busy;
    hi    = HI;
    lo    = LO;
    e     = err;
  endtask

  int          lat;
  logic        busy1;
  logic        busyd;
  logic [31:0] rhi;
  logic [31:0] rlo;
  logic        rerr;
  int          ndone;
  int          dcyc;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    A      = 32'd0;
    B      = 32'd0;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, "mul 7*-3"};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, "mul -1*-1"};
    vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34, "mul max*max"};
    vecs[3]  = '{1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 34, "mul min*1"};
`ifdef MULDIV_DIV_EN
    vecs[4]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div -7/2"};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, "div min/-1"};
    vecs[6]  = '{1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2,  "div 5/0"};
    vecs[8]  = '{1'b1, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 34, "div 9/3"};
    vecs[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, "div 7/-2"};
    vecs[10] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, "div 100/7"};
`else
    vecs[4]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        1'b1, 2,  "div -7/2 off"};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, 2,  "div min/-1 off"};
    vecs[6]  = '{1'b1, 32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 2,  "div 5/0 off"};
    vecs[8]  = '{1'b1, 32'd9,        32'd3,        32'd0,        32'd0,        1'b1, 2,  "div 9/3 off"};
    vecs[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        1'b1, 2,  "div 7/-2 off"};
    vecs[10] = '{1'b1, 32'd100,      32'd7,        32'd0,        32'd0,        1'b1, 2,  "div 100/7 off"};
`endif
    vecs[7]  = '{1'b0, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 34, "mul 3*4 after err"};
    vecs[11] = '{1'b0, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, "mul -2^16*2^16"};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err",  {31'd0, err},  32'd0);
    chk("reset HI",   HI, 32'd0);
    chk("reset LO",   LO, 32'd0);
    clr = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk({vecs[i].name, " done idle"}, {31'd0, done}, 32'd0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1, busyd, rhi, rlo, rerr);
      chk({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, " busy t+1"}, {31'd0, busy1}, 32'd1);
      chk({vecs[i].name, " busy done"}, {31'd0, busyd}, 32'd0);
      chk({vecs[i].name, " HI"}, rhi, vecs[i].hi);
      chk({vecs[i].name, " LO"}, rlo, vecs[i].lo);
      chk({vecs[i].name, " err"}, {31'd0, rerr}, {31'd0, vecs[i].err});
    end

    // Back-to-back: second start issued in the DONE cycle of the first
    @(negedge clk);
    run_op(1'b0, 32'h80000000, 32'h80000000, lat, busy1, busyd, rhi, rlo, rerr);
    chk("b2b first latency", 32'(lat), 32'd34);
    chk("b2b first HI", rhi, 32'h40000000);
    chk("b2b first LO", rlo, 32'h00000000);
    run_op(1'b0, 32'd3, 32'd4, lat, busy1, busyd, rhi, rlo, rerr);
    chk("b2b second latency", 32'(lat), 32'd34);
    chk("b2b second HI", rhi, 32'd0);
    chk("b2b second LO", rlo, 32'd12);

    // Inputs and start toggled while busy must be ignored
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    op = 1'b1;
`else
    op = 1'b0;
`endif
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    rhi   = 32'd0;
    rlo   = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
        rhi  = HI;
        rlo  = LO;
      end
      if (c >= 5 && c <= 20) begin
        start = c[0];
        A     = $urandom;
        B     = $urandom;
        op    = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore done count", 32'(ndone), 32'd1);
    chk("ignore done cycle", 32'(dcyc), 32'd34);
`ifdef MULDIV_DIV_EN
    chk("ignore HI", rhi, 32'd2);
    chk("ignore LO", rlo, 32'd14);
`else
    chk("ignore HI", rhi, 32'd0);
    chk("ignore LO", rlo, 32'd700);
`endif

    // Clear at t+10 of a multiply aborts without a done pulse
    op    = 1'b0;
    A     = 32'd123;
    B     = 32'd456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr busy", {31'd0, busy}, 32'd0);
    chk("clr HI", HI, 32'd0);
    chk("clr LO", LO, 32'd0);
    chk("clr err", {31'd0, err}, 32'd0);
    ndone = 0;
    for (int c = 11; c <= 40; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("clr no done", 32'(ndone), 32'd0);

    // Unit recovers after the abort
    run_op(1'b0, 32'hFFFFFFFB, 32'd6, lat, busy1, busyd, rhi, rlo, rerr);
    chk("post clr latency", 32'(lat), 32'd34);
    chk("post clr HI", rhi, 32'hFFFFFFFF);
    chk("post clr LO", rlo, 32'hFFFFFFE2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Sequential signed 32×32 multiply / 32÷32 divide unit in the datapath. It takes operands from the bus/Y-register side, iterates one bit per clock, and delivers a 64-bit HI/LO result to the Z-register capture path. The control unit holds the Z-capture step until `done` is high. It replaces the single-cycle `A*B` and `A/B` paths for the `mul` and `div` opcodes.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `A` in 32: multiplicand / dividend, two's complement.
- `B` in 32: multiplier / divisor, two's complement.
- `op` in 1: operation select, 0 = multiply, 1 = divide.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO/err are valid.
- `HI` out 32: upper product, or remainder.
- `LO` out 32: lower product, or quotient.
- `err` out 1: divide by zero, or divide not compiled in. Valid with `done`.

## Operation
- Reset state: IDLE. `busy`=0, `done`=0, `err`=0, `HI`=0, `LO`=0, iteration counter=0.
- States and transitions:
  - IDLE → CALC when `start`=1.
  - CALC → CALC for 32 cycles, then → FIX.
  - FIX → DONE.
  - DONE → IDLE. If `start`=1 in DONE, go straight to CALC (back-to-back operations).
- Operand capture: A, B and op are registered on the accepting edge. Later changes to the inputs are ignored.
- Multiply: radix-2 Booth.
  - 65-bit accumulator {P_hi[32:0], P_lo[31:0]} plus Booth bit q₋₁.
  - Each CALC cycle: add or subtract sign-extended B per {q0, q₋₁}, then arithmetic shift right by 1.
  - FIX: copy to HI/LO. No correction is needed.
- Divide: magnitude restoring division.
  - At accept: |A|, |B| are stored; sign_q = A[31]^B[31]; sign_r = A[31].
  - Each CALC cycle: shift {R, Q} left by 1; trial R−|B| (33-bit); if non-negative, keep it and set the Q LSB.
  - FIX: negate Q if sign_q; negate R if sign_r. LO=Q, HI=R.
  - The remainder takes the sign of the dividend.
- Overflow: 0x80000000 ÷ −1 → LO=0x80000000, HI=0 (wraps); `err`=0.
- Divide by zero (B=0, op=1):
  - Go directly to FIX, skipping CALC.
  - Result: HI=A, LO=0xFFFFFFFF, `err`=1.
- HI/LO/err update only on the FIX→DONE edge. They hold until the next result or `clr`.
- `start` while `busy`=1 is ignored: no queueing, no restart.
- `clr` mid-operation: aborts. The next cycle is IDLE with all outputs 0, and no `done` is issued.

## Timing
- `start` sampled high at the end of cycle t (in IDLE or DONE).
- Normal operation:
  - `busy`=1 in cycles t+1 … t+33 (32 CALC + 1 FIX).
  - `done`=1 and HI/LO valid in cycle t+34.
  - `busy`=0 in the DONE cycle.
- Divide by zero / divide disabled: FIX in t+1, `done` in t+2.
- Throughput: one operation per 34 cycles, with start issued in the DONE cycle.
- `clr` has priority over `start`.

## Configuration
- `MULDIV_DIV_EN`
  - Defined: divide datapath compiled in, as described above.
  - Undefined: no divide hardware. `op`=1 takes the divide-by-zero timing (`done` at t+2) with HI=0, LO=0, `err`=1. Multiply is unchanged.

## Structure
- Package `muldiv_pkg`:
  - state enum {IDLE, CALC, FIX, DONE};
  - `OP_MUL`=1'b0, `OP_DIV`=1'b1;
  - `MULDIV_ITER`=32;
  - `DIV0_LO`=32'hFFFFFFFF.
- Sub-module `muldiv_addsub`: 33-bit combinational add/subtract with a `sub` control. It is shared by the Booth step and the divide trial subtraction.
- Top level holds the FSM, counter, operand/accumulator registers and sign-fix logic.

## Test plan
- Multiply 7 × −3 (A=7, B=0xFFFFFFFD):
  - `done` exactly at t+34.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB, err=0.
- Multiply 0x80000000 × 0x80000000:
  - HI=0x40000000, LO=0x00000000.
  - Back-to-back start in the DONE cycle: 3 × 4 → LO=12 at the next t+34.
- Divide −7 ÷ 2:
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - Divide 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide 5 ÷ 0:
  - `done` at t+2, err=1, HI=5, LO=0xFFFFFFFF.
  - Without `MULDIV_DIV_EN`, divide 9 ÷ 3: `done` at t+2, err=1, HI=LO=0.
- Assert `clr` at t+10 of a multiply:
  - Cycle t+11: `busy`=0, HI=LO=0.
  - No `done` in t+11 … t+40.
- Toggle `start` and change A/B/op during t+5 … t+20 of 100 ÷ 7:
  - Ignored.
  - LO=14, HI=2, one `done` pulse at t+34.
